// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter
//   Round-robin arbiter that shares one I2C master engine between NREQ requesters.
//   It latches the winner's address/data/direction and issues a single start pulse.
//   It then waits for the master to complete and returns a one-cycle done pulse
//   with a completion status to the requester it served.
//
//   Optional feature: define I2C_ARB_TIMEOUT_EN to compile in a watchdog. The
//   watchdog ends a transaction with status 2'b10 after TIMEOUT_CYCLES cycles
//   spent waiting on the master.
//
// Ports
//   clk, reset          system clock; asynchronous active-low reset
//   req/req_addr/       per-requester request level, 7-bit address, write byte,
//   req_data/req_rw     and direction (0 = write, 1 = read)
//   grant               one-hot, high from grant until the done pulse
//   done/status/rd_data completion pulse, status (00 ok, 01 NACK, 10 timeout), read byte
//   m_start/m_addr/     start pulse and latched transaction fields toward the master
//   m_data/m_rw
//   m_busy/m_done/      master progress, completion pulse, NACK flag and read byte
//   m_nack/m_rd_data
module i2c_master_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_rw,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [1:0]        status,
    output logic [7:0]        rd_data,
    output logic              m_start,
    output logic [6:0]        m_addr,
    output logic [7:0]        m_data,
    output logic              m_rw,
    input  logic              m_busy,
    input  logic              m_done,
    input  logic              m_nack,
    input  logic [7:0]        m_rd_data
);
    localparam int unsigned IDXW = $clog2(NREQ);

    typedef enum logic [2:0] {StIdle, StStart, StWaitBusy, StWaitDone, StResp} state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   last_q, last_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [6:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              rw_q, rw_d;
    logic [1:0]        status_q, status_d;
    logic [7:0]        rd_q, rd_d;

    logic [IDXW-1:0]   cand;
    logic [IDXW-1:0]   win_idx;
    logic              win_found;
    logic [6:0]        sel_addr;
    logic [7:0]        sel_data;
    logic              sel_rw;
    logic              timed_out;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counter is zero in the first WAIT_BUSY cycle, so the limit is hit after
    // exactly TIMEOUT_CYCLES waiting cycles.
    assign timed_out = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StStart) begin
            cnt_d = '0;
        end else if (state_q == StWaitBusy || state_q == StWaitDone) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam logic [31:0] TimeoutVec = 32'(TIMEOUT_CYCLES);
    logic unused_timeout;

    assign unused_timeout = ^TimeoutVec;
    assign timed_out      = 1'b0;
`endif

    // Round-robin search starting one past the last served requester, wrapping at NREQ.
    always_comb begin
        cand      = last_q;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == IDXW'(NREQ - 1)) ? '0 : cand + IDXW'(1);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_rw   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDXW'(i)) begin
                sel_addr = req_addr[7*i +: 7];
                sel_data = req_data[8*i +: 8];
                sel_rw   = req_rw[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        idx_d    = idx_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rw_d     = rw_q;
        status_d = status_q;
        rd_d     = rd_q;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    idx_d   = win_idx;
                    grant_d = NREQ'(1) << win_idx;
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                    rw_d    = sel_rw;
                    state_d = StStart;
                end
            end
            StStart: state_d = StWaitBusy;
            StWaitBusy, StWaitDone: begin
                // Completion takes priority; an early m_done in WAIT_BUSY also completes.
                if (m_done) begin
                    status_d = m_nack ? 2'b01 : 2'b00;
                    rd_d     = m_rd_data;
                    state_d  = StResp;
                end else if (timed_out) begin
                    status_d = 2'b10;
                    rd_d     = '0;
                    state_d  = StResp;
                end else if (state_q == StWaitBusy && m_busy) begin
                    state_d = StWaitDone;
                end
            end
            StResp: begin
                grant_d  = '0;
                last_d   = idx_q;
                status_d = '0;
                rd_d     = '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            last_q   <= IDXW'(NREQ - 1);
            idx_q    <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rw_q     <= 1'b0;
            status_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rw_q     <= rw_d;
            status_q <= status_d;
            rd_q     <= rd_d;
        end
    end

    assign grant   = grant_q;
    assign m_start = (state_q == StStart);
    assign m_addr  = addr_q;
    assign m_data  = data_q;
    assign m_rw    = rw_q;
    assign done    = (state_q == StResp) ? grant_q : '0;
    assign status  = (state_q == StResp) ? status_q : 2'b00;
    assign rd_data = (state_q == StResp) ? rd_q : 8'h00;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter
//   Self-checking bench for i2c_master_arbiter (NREQ = 4). A directed table covers
//   single write, contention, NACK/read retry and field stability. Hand-written
//   sequences cover reset mid-transfer and the optional watchdog. A randomized
//   phase checks grant order against a round-robin reference model.
module tb_i2c_master_arbiter;
    localparam int N = 4;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [7*N-1:0]  req_addr;
    logic [8*N-1:0]  req_data;
    logic [N-1:0]    req_rw;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [1:0]      status;
    logic [7:0]      rd_data;
    logic            m_start;
    logic [6:0]      m_addr;
    logic [7:0]      m_data;
    logic            m_rw;
    logic            m_busy;
    logic            m_done;
    logic            m_nack;
    logic [7:0]      m_rd_data;

    logic [6:0] addr_m [N];
    logic [7:0] data_m [N];
    logic       rw_m   [N];

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int unsigned last_m = N - 1;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_addr[7*g +: 7] = addr_m[g];
        assign req_data[8*g +: 8] = data_m[g];
        assign req_rw[g]          = rw_m[g];
    end

    i2c_master_arbiter #(
        .NREQ           (N),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_rw    (req_rw),
        .grant     (grant),
        .done      (done),
        .status    (status),
        .rd_data   (rd_data),
        .m_start   (m_start),
        .m_addr    (m_addr),
        .m_data    (m_data),
        .m_rw      (m_rw),
        .m_busy    (m_busy),
        .m_done    (m_done),
        .m_nack    (m_nack),
        .m_rd_data (m_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference rule: first pending requester at last+1, last+2, ... modulo N.
    function automatic int unsigned rr_pick(logic [N-1:0] pend, int unsigned last);
        for (int k = 1; k <= N; k++) begin
            if (((pend >> ((last + k) % N)) & 4'd1) != 4'd0) return (last + k) % N;
        end
        return 0;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
            chk("done_within_grant", 32'(done & ~grant), 32'd0);
        end
    end

    typedef struct {
        bit          pre_rst;
        logic [3:0]  set_req;
        logic [3:0]  clr_req;
        int unsigned exp_idx;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic        rw;
        logic        nack;
        logic [7:0]  rd;
        int unsigned bdly;
        int unsigned len;
        bit          no_busy;
        bit          poke;
    } vec_t;

    vec_t tbl [9];

    task automatic apply_set(input logic [3:0] s, input logic [6:0] a, input logic [7:0] d,
                             input logic rw);
        int unsigned c;
        c = 0;
        for (int i = 0; i < N; i++) begin
            if (s[i]) begin
                addr_m[i] = a + 7'(c);
                data_m[i] = d + 8'(c);
                rw_m[i]   = rw;
                c++;
            end
        end
        req = req | s;
    endtask

    // Serves one transaction as the master; must be entered with the DUT idle.
    task automatic serve(input int unsigned idx, input logic nack, input logic [7:0] rdv,
                         input int unsigned bdly, input int unsigned len, input bit no_busy,
                         input bit poke, input logic [3:0] clr);
        int unsigned n;
        logic [6:0]  ea;
        logic [7:0]  ed;
        logic        er;
        n = 0;
        while (m_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 32'(m_start), 32'd1);
        if (m_start !== 1'b1) return;
        ea = addr_m[idx];
        ed = data_m[idx];
        er = rw_m[idx];
        chk("grant_at_start", 32'(grant), 32'(1) << idx);
        chk("m_addr", 32'(m_addr), 32'(ea));
        chk("m_data", 32'(m_data), 32'(ed));
        chk("m_rw", 32'(m_rw), 32'(er));
        @(negedge clk);
        chk("start_one_pulse", 32'(m_start), 32'd0);
        if (poke) begin
            addr_m[1] = 7'h11;
            req[1]    = 1'b0;
        end
        if (!no_busy) begin
            repeat (bdly) @(negedge clk);
            m_busy = 1'b1;
            repeat (len) @(negedge clk);
        end
        m_done    = 1'b1;
        m_nack    = nack;
        m_rd_data = rdv;
        @(negedge clk);
        m_done    = 1'b0;
        m_busy    = 1'b0;
        m_nack    = 1'b0;
        m_rd_data = 8'($urandom);
        chk("done_pulse", 32'(done), 32'(1) << idx);
        chk("status", 32'(status), {31'd0, nack});
        if (er) chk("rd_data", 32'(rd_data), 32'(rdv));
        chk("m_addr_stable", 32'(m_addr), 32'(ea));
        chk("grant_in_done", 32'(grant), 32'(1) << idx);
        last_m = idx;
        req    = req & ~clr;
        @(negedge clk);
        chk("done_clear", 32'(done), 32'd0);
        chk("grant_clear", 32'(grant), 32'd0);
        chk("status_idle", 32'(status), 32'd0);
    endtask

    initial begin
        int unsigned starts;
        int unsigned n;
        int unsigned e;
        logic [3:0]  raise;
        logic [3:0]  clr;

        tbl[0] = '{0, 4'b0001, 4'b0001, 0, 7'h2A, 8'hAA, 1'b0, 1'b0, 8'h00, 1, 2, 0, 0};
        tbl[1] = '{1, 4'b1111, 4'b0000, 0, 7'h10, 8'h30, 1'b0, 1'b0, 8'h00, 0, 1, 0, 0};
        tbl[2] = '{0, 4'b0000, 4'b0000, 1, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0, 1, 0};
        tbl[3] = '{0, 4'b0000, 4'b0000, 2, 7'h00, 8'h00, 1'b0, 1'b1, 8'h00, 2, 3, 0, 0};
        tbl[4] = '{0, 4'b0000, 4'b0000, 3, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1, 1, 0, 0};
        tbl[5] = '{0, 4'b0000, 4'b1111, 0, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00, 0, 2, 0, 0};
        tbl[6] = '{0, 4'b0100, 4'b0000, 2, 7'h50, 8'h00, 1'b1, 1'b1, 8'h00, 1, 2, 0, 0};
        tbl[7] = '{0, 4'b0000, 4'b0100, 2, 7'h00, 8'h00, 1'b0, 1'b0, 8'h5C, 0, 1, 0, 0};
        tbl[8] = '{0, 4'b0010, 4'b0000, 1, 7'h33, 8'h44, 1'b0, 1'b0, 8'h00, 1, 2, 0, 1};

        reset     = 1'b0;
        req       = '0;
        m_busy    = 1'b0;
        m_done    = 1'b0;
        m_nack    = 1'b0;
        m_rd_data = '0;
        for (int i = 0; i < N; i++) begin
            addr_m[i] = '0;
            data_m[i] = '0;
            rw_m[i]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_m_start", 32'(m_start), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b1;

        foreach (tbl[v]) begin
            if (tbl[v].pre_rst) begin
                reset = 1'b0;
                apply_set(tbl[v].set_req, tbl[v].addr, tbl[v].data, tbl[v].rw);
                repeat (3) @(negedge clk);
                reset  = 1'b1;
                last_m = N - 1;
            end else begin
                apply_set(tbl[v].set_req, tbl[v].addr, tbl[v].data, tbl[v].rw);
            end
            serve(tbl[v].exp_idx, tbl[v].nack, tbl[v].rd, tbl[v].bdly, tbl[v].len,
                  tbl[v].no_busy, tbl[v].poke, tbl[v].clr_req);
            if (tbl[v].poke) begin
                starts = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (m_start === 1'b1 || done !== '0) starts++;
                end
                chk("no_restart_after_drop", 32'(starts), 32'd0);
            end
        end

        // Reset while the master is mid-transfer.
        apply_set(4'b0110, 7'h21, 8'h5A, 1'b0);
        n = 0;
        while (m_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rst_start_seen", 32'(m_start), 32'd1);
        @(negedge clk);
        m_busy = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_m_addr", 32'(m_addr), 32'd0);
        chk("mid_rst_m_data", 32'(m_data), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_status", 32'(status), 32'd0);
        m_busy = 1'b0;
        req    = '0;
        apply_set(4'b1111, 7'h40, 8'h80, 1'b0);
        starts = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== '0) starts++;
        end
        chk("mid_rst_no_done", 32'(starts), 32'd0);
        reset  = 1'b1;
        last_m = N - 1;
        serve(rr_pick(req, last_m), 1'b0, 8'h00, 0, 1, 0, 0, 4'b1111);

        // Randomized traffic against the round-robin reference model.
        for (int it = 0; it < 40; it++) begin
            raise = 4'($urandom_range(0, 15)) & ~req;
            if ((req | raise) == 4'd0) raise = 4'd1 << $urandom_range(0, N - 1);
            for (int i = 0; i < N; i++) begin
                if (raise[i]) begin
                    addr_m[i] = 7'($urandom);
                    data_m[i] = 8'($urandom);
                    rw_m[i]   = 1'($urandom);
                end
            end
            req = req | raise;
            e   = rr_pick(req, last_m);
            clr = ($urandom_range(0, 3) != 0) ? (4'd1 << e) : 4'd0;
            serve(e, 1'($urandom), 8'($urandom), $urandom_range(0, 2), $urandom_range(1, 4),
                  $urandom_range(0, 4) == 0, 0, clr);
        end
        req = '0;
        repeat (3) @(negedge clk);

`ifdef I2C_ARB_TIMEOUT_EN
        // Master never responds: watchdog must end the transfer.
        apply_set(4'b1000, 7'h3C, 8'hC3, 1'b1);
        n = 0;
        while (m_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("to_start_seen", 32'(m_start), 32'd1);
        n = 0;
        while (done === '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("to_done", 32'(done), 32'b1000);
        chk("to_status", 32'(status), 32'd2);
        chk("to_rd_data", 32'(rd_data), 32'd0);
        chk("to_latency", 32'(n >= 95 && n <= 110), 32'd1);
        req = '0;
        repeat (3) @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
